// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared types and constants for the loadable instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/imem_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_sdp_ram
// Brief    : Simple dual-port RAM, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module imem_sdp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // No reset on the array or read register so the storage maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : imem_loadable
// Brief    : Run-time loadable instruction memory with a checked fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loadable
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault,
    input  logic                  load_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  busy,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   prog_words
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     prog_words_q, prog_words_d;
    logic                    load_error_q, load_error_d;
    logic                    busy_q, busy_d;
    logic                    load_ready_q, load_ready_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic                    fetch_fault_q, fetch_fault_d;
    logic                    use_mem_q, use_mem_d;

    logic [31:0]             w_offset;
    logic [31:0]             w_idx;
    logic [1:0]              w_fault_reason;
    logic                    w_in_prog;
    logic                    w_fetch_go;
    logic                    w_beat;
    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Underflow below BASE_ADDR wraps to a huge index and lands in the range fault.
    assign w_offset  = fetch_addr - BASE_ADDR;
    assign w_idx     = w_offset >> 2;
    assign w_in_prog = (w_idx < 32'(prog_words_q));

    always_comb begin
        w_fault_reason = FAULT_NONE;
        if (fetch_addr[1:0] != 2'b00) begin
            w_fault_reason = FAULT_MISALIGN;
        end else if ((w_idx >> ADDR_WIDTH) != 32'd0) begin
            w_fault_reason = FAULT_RANGE;
        end
    end

    assign w_fetch_go = fetch_req && (state_q == RUN) && !load_start;
    assign w_beat     = load_valid && load_ready_q;
    assign w_rd_en    = w_fetch_go && (w_fault_reason == FAULT_NONE) && w_in_prog;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        prog_words_d  = prog_words_q;
        load_error_d  = load_error_q;
        busy_d        = busy_q;
        load_ready_d  = load_ready_q;

        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d      = LOAD;
                    wr_ptr_d     = '0;
                    prog_words_d = '0;
                    load_error_d = 1'b0;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b1;
                end
            end
            LOAD: begin
                if (w_beat) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (load_last) begin
                        prog_words_d = {1'b0, wr_ptr_q} + 1'b1;
                        state_d      = RUN;
                        busy_d       = 1'b0;
                        load_ready_d = 1'b0;
                    end else if (wr_ptr_q == '1) begin
                        prog_words_d = {1'b1, {ADDR_WIDTH{1'b0}}};
                        load_error_d = 1'b1;
                        state_d      = RUN;
                        busy_d       = 1'b0;
                        load_ready_d = 1'b0;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        fetch_valid_d = w_fetch_go;
        fetch_fault_d = w_fetch_go && (w_fault_reason != FAULT_NONE);
        use_mem_d     = w_rd_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            wr_ptr_q      <= '0;
            prog_words_q  <= '0;
            load_error_q  <= 1'b0;
            busy_q        <= 1'b0;
            load_ready_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            use_mem_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            prog_words_q  <= prog_words_d;
            load_error_q  <= load_error_d;
            busy_q        <= busy_d;
            load_ready_q  <= load_ready_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            use_mem_q     <= use_mem_d;
        end
    end

    imem_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_beat),
        .waddr (wr_ptr_q),
        .wdata (load_data),
        .re    (w_rd_en),
        .raddr (w_idx[ADDR_WIDTH-1:0]),
        .rdata (w_rd_data)
    );

    // The RAM read register is unreset, so anything not read from it is forced to NOP.
    assign fetch_instr = use_mem_q ? w_rd_data : DATA_WIDTH'(NOP);
    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign load_ready  = load_ready_q;
    assign busy        = busy_q;
    assign load_error  = load_error_q;
    assign prog_words  = prog_words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loadable
// Brief    : Scoreboard bench for imem_loadable: directed loads and fetches.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loadable;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_instr;
    logic          fetch_fault;
    logic          load_start;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          busy;
    logic          load_error;
    logic [AW:0]   prog_words;

    always #5 clk = ~clk;

    imem_loadable #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .busy        (busy),
        .load_error  (load_error),
        .prog_words  (prog_words)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ld_buf [0:DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
        exp_t e;
        e.instr = ei;
        e.fault = ef;
        exp_q.push_back(e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic load_burst(input int n, input bit with_last);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_entry_busy",  {31'b0, busy},       32'd1);
        check("load_entry_ready", {31'b0, load_ready}, 32'd1);
        check("load_entry_words", 32'(prog_words),     32'd0);
        check("load_entry_err",   {31'b0, load_error}, 32'd0);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = ld_buf[i];
            load_last  = with_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Monitor: every presented fetch result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch_valid", {31'b0, fetch_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("fetch_instr", fetch_instr, e.instr);
                check("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
            end
        end
    end

    initial begin
        int got;
        int cyc;

        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fetch_instr", fetch_instr,          32'd0);
        check("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_load_ready",  {31'b0, load_ready},  32'd0);
        check("rst_busy",        {31'b0, busy},        32'd0);
        check("rst_load_error",  {31'b0, load_error},  32'd0);
        check("rst_prog_words",  32'(prog_words),      32'd0);
        reset = 1'b1;
        tick();

        fetch(32'h0, 32'h0, 1'b0);

        // Test-plan program; the fetch is issued in the first cycle after the last beat.
        ld_buf[0] = 32'h2004_0005;
        ld_buf[1] = 32'h0000_1026;
        ld_buf[2] = 32'h0C00_0004;
        ld_buf[3] = 32'h1000_FFFF;
        load_burst(4, 1'b1);
        check("prog4_busy",  {31'b0, busy},       32'd0);
        check("prog4_ready", {31'b0, load_ready}, 32'd0);
        check("prog4_words", 32'(prog_words),     32'd4);
        fetch(32'h8, 32'h0C00_0004, 1'b0);

        fetch(32'h10,        32'h0, 1'b0);
        fetch(32'h6,         32'h0, 1'b1);
        fetch(DEPTH * 4,     32'h0, 1'b1);
        fetch(32'hFFFF_FFFC, 32'h0, 1'b1);
        fetch(32'h0,         32'h2004_0005, 1'b0);
        fetch(32'h4,         32'h0000_1026, 1'b0);
        fetch(32'hC,         32'h1000_FFFF, 1'b0);

        // Fetch alongside load_start and during busy are dropped.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        check("fetch_with_start_dropped", {31'b0, fetch_valid}, 32'd0);
        check("rand_busy",                {31'b0, busy},        32'd1);
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        tick();
        fetch_req  = 1'b0;
        check("fetch_while_busy_dropped", {31'b0, fetch_valid}, 32'd0);

        for (int i = 0; i < 6; i++) ld_buf[i] = 32'h5A5A_0000 + 32'(i * 17);
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 200) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = load_valid ? ld_buf[got] : (32'hBAD0_0000 | 32'(cyc));
            load_last  = load_valid && (got == 5);
            tick();
            if (load_valid) got++;
            cyc++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("rand_beats_done", 32'(got),            32'd6);
        check("rand_busy_done",  {31'b0, busy},       32'd0);
        check("rand_words",      32'(prog_words),     32'd6);
        for (int i = 0; i < 6; i++) fetch(32'(i * 4), ld_buf[i], 1'b0);
        fetch(32'd24, 32'h0, 1'b0);

        // Overflow: DEPTH+1 beats, no load_last; the extra beat must be refused.
        for (int i = 0; i < DEPTH; i++) ld_buf[i] = 32'hA500_0000 + 32'(i);
        ld_buf[DEPTH] = 32'hDEAD_BEEF;
        load_burst(DEPTH + 1, 1'b0);
        check("ovf_error", {31'b0, load_error}, 32'd1);
        check("ovf_words", 32'(prog_words),     32'(DEPTH));
        check("ovf_ready", {31'b0, load_ready}, 32'd0);
        check("ovf_busy",  {31'b0, busy},       32'd0);
        fetch(32'h0,               32'hA500_0000, 1'b0);
        fetch(32'((DEPTH - 1) * 4), 32'hA500_00FF, 1'b0);

        // Reset mid-load aborts and hides everything.
        ld_buf[0] = 32'h1111_1111;
        ld_buf[1] = 32'h2222_2222;
        load_burst(2, 1'b0);
        reset = 1'b0;
        #1;
        check("abort_busy",  {31'b0, busy},       32'd0);
        check("abort_words", 32'(prog_words),     32'd0);
        check("abort_error", {31'b0, load_error}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        fetch(32'h0, 32'h0, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
# imem_loadable

Parametrised synchronous instruction memory for the single-cycle and multi-cycle MIPS cores, replacing the hard-coded program ROM. Programs are streamed in at run time through a valid/ready loader port. The CPU fetches through a registered read port with alignment and range checking. Addresses beyond the loaded program return NOP, so a fresh core executes harmlessly until a program is loaded.

## Interface
- ADDR_WIDTH, 8: word-index bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: instruction width.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low: asserted when 0, released synchronously by the integrator.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  32  byte address of the fetch.
- fetch_valid  out  1  fetch_instr/fetch_fault are valid this cycle.
- fetch_instr  out  DATA_WIDTH  fetched instruction.
- fetch_fault  out  1  misaligned or out-of-range fetch; fetch_instr = NOP.
- load_start  in  1  one-cycle pulse that begins a new program load.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block accepts a load beat.
- load_data  in  DATA_WIDTH  instruction word to store.
- load_last  in  1  marks the final word of the program.
- busy  out  1  load in progress; fetches are not serviced.
- load_error  out  1  sticky overflow flag; cleared by the next accepted load_start.
- prog_words  out  ADDR_WIDTH+1  number of valid program words.

## Operation
- FSM states: RUN, LOAD.
  - RUN -> LOAD on load_start.
  - LOAD -> RUN on an accepted beat with load_last, or on overflow.
  - load_start in LOAD is ignored.
- Entering LOAD: wr_ptr = 0, prog_words = 0, load_error = 0, busy = 1, load_ready = 1.
- Accepted beat (load_valid & load_ready): mem[wr_ptr] = load_data, wr_ptr++.
  - With load_last: prog_words = wr_ptr+1; go to RUN.
- Overflow: a beat without load_last accepted at wr_ptr = DEPTH-1.
  - The word is written, load_error = 1, prog_words = DEPTH, go to RUN.
  - Further beats are not accepted (load_ready = 0).
- Fetch (RUN only):
  - idx = (fetch_addr - BASE_ADDR) >> 2, computed in 32 bits.
  - fault if fetch_addr[1:0] != 0, or idx >= DEPTH (including underflow wrap when fetch_addr < BASE_ADDR).
  - Non-faulting with idx >= prog_words: fetch_instr = NOP (32'h0000_0000), fault = 0.
  - Otherwise fetch_instr = mem[idx].
- Fetch in LOAD, or in the same cycle as an accepted load_start: dropped. fetch_valid = 0 next cycle; the requester retries once busy is low.
- Memory contents are not reset; only prog_words gates visibility.

## Timing
- Fetch latency is 1 cycle: request at edge N -> fetch_valid/instr/fault held from N+1 until the next edge. One fetch per cycle, fully pipelined.
- fetch_valid = 0 in any cycle after a cycle without a serviced fetch_req.
- load_start at edge N -> busy = 1 and load_ready = 1 from N+1. The first beat can be accepted at edge N+1.
- Last beat accepted at edge M -> busy = 0 and prog_words updated from M+1. A fetch issued in cycle M+1 sees the new program.
- Reset values: fetch_valid 0, fetch_instr 0, fetch_fault 0, load_ready 0, busy 0, load_error 0, prog_words 0, state RUN.
- Reset mid-load aborts the load: prog_words = 0, all addresses read NOP.

## Structure
- Package imem_pkg: NOP constant, state enum {RUN, LOAD}, fault-reason localparams.
- Sub-module imem_sdp_ram: simple dual-port RAM, one write port and one registered read port, DEPTH x DATA_WIDTH, no reset on the array.
- Top level holds the FSM, pointers, range check and output registers.

## Test plan
- Load 0x20040005, 0x00001026, 0x0C000004, 0x1000FFFF (load_last on the 4th word); fetch 0x8 -> fetch_instr 0x0C000004 one cycle later, prog_words = 4.
- After that load, fetch 0x10 -> 0x00000000 with fault = 0; fetch 0x6 -> fault = 1; fetch DEPTH*4 -> fault = 1.
- Back-to-back fetches 0x0, 0x4, 0xC on consecutive cycles -> 0x20040005, 0x00001026, 0x1000FFFF on consecutive cycles.
- Stream DEPTH+1 words with no load_last -> load_error = 1 after word DEPTH, prog_words = DEPTH, load_ready = 0, and word DEPTH is not written.
- Assert reset after 2 of 4 beats -> busy = 0, prog_words = 0; fetch 0x0 -> 0x00000000.
- fetch_req in the same cycle as load_start, and during busy -> no fetch_valid; load_valid toggled randomly -> only handshaken beats are stored.
